// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator block.
package sum_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int unsigned SW_DEF        = 17;
  localparam int unsigned TW_DEF        = 9;
  localparam int unsigned ACC_W_DEF     = 24;
  localparam int unsigned CNT_W_DEF     = 8;
  localparam int unsigned BLOCK_LEN_DEF = 4;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample input and result frame handshakes between adder stage, accumulator and report logic.
interface sum_accumulator_if #(
  parameter int unsigned SW    = sum_acc_pkg::SW_DEF,
  parameter int unsigned TW    = sum_acc_pkg::TW_DEF,
  parameter int unsigned ACC_W = sum_acc_pkg::ACC_W_DEF,
  parameter int unsigned CNT_W = sum_acc_pkg::CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    s_in;
  logic [TW-1:0]    t_in;
  logic             ovf_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] acc_t;
  logic             sat;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output in_valid, s_in, t_in, ovf_in, out_ready,
    input  in_ready, out_valid, acc_s, acc_t, sat, ovf_cnt
  );

  modport slave (
    input  in_valid, s_in, t_in, ovf_in, out_ready,
    output in_ready, out_valid, acc_s, acc_t, sat, ovf_cnt
  );

endinterface

// File: rtl/sum_accumulator_sat_add_u.sv
// Unsigned W-bit adder that clamps to all-ones on carry out and flags the clamp.
module sat_add_u #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         sat_c
);

  logic [W:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    sat_c = full[W];
    sum_c = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates BLOCK_LEN adder samples into saturating totals and presents one frame per block.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned SW        = SW_DEF,
  parameter int unsigned TW        = TW_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  sum_accumulator_if.slave bus
);

  // Sample counter must reach BLOCK_LEN independently of the overflow counter width.
  localparam int unsigned SMP_W = $clog2(BLOCK_LEN + 1);

  state_e           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] acc_s_q;
  logic [ACC_W-1:0] acc_t_q;
  logic             sat_q;
  logic [CNT_W-1:0] ovf_q;
  logic [SMP_W-1:0] sample_cnt;

  logic [ACC_W-1:0] nxt_s_c;
  logic [ACC_W-1:0] nxt_t_c;
  logic [CNT_W-1:0] nxt_ovf_c;
  logic             sat_s_c;
  logic             sat_t_c;
  logic             ovf_sat_unused;
  logic             accept_c;
  logic             last_c;

  sat_add_u #(.W(ACC_W)) u_add_s (
    .a     (acc_s_q),
    .b     (ACC_W'(bus.s_in)),
    .sum_c (nxt_s_c),
    .sat_c (sat_s_c)
  );

  sat_add_u #(.W(ACC_W)) u_add_t (
    .a     (acc_t_q),
    .b     (ACC_W'(bus.t_in)),
    .sum_c (nxt_t_c),
    .sat_c (sat_t_c)
  );

  sat_add_u #(.W(CNT_W)) u_add_ovf (
    .a     (ovf_q),
    .b     (CNT_W'(bus.ovf_in)),
    .sum_c (nxt_ovf_c),
    .sat_c (ovf_sat_unused)
  );

  assign accept_c = bus.in_valid & in_ready_q;
  assign last_c   = (sample_cnt == SMP_W'(BLOCK_LEN - 1));

  // State, counters and registered handshake outputs; clear outranks accept and frame handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_s_q     <= '0;
      acc_t_q     <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= '0;
      sample_cnt  <= '0;
    end else if (clear) begin
      state       <= ST_ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_s_q     <= '0;
      acc_t_q     <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= '0;
      sample_cnt  <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept_c) begin
            acc_s_q    <= nxt_s_c;
            acc_t_q    <= nxt_t_c;
            sat_q      <= sat_q | sat_s_c | sat_t_c;
            ovf_q      <= nxt_ovf_c;
            sample_cnt <= sample_cnt + SMP_W'(1);
            if (last_c) begin
              state       <= ST_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state       <= ST_ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_s_q     <= '0;
            acc_t_q     <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= '0;
            sample_cnt  <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_s     = acc_s_q;
  assign bus.acc_t     = acc_t_q;
  assign bus.sat       = sat_q;
  assign bus.ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator across four parameterisations sharing clock and reset.
module tb_sum_accumulator;

  logic clk;
  logic rst_n;
  logic clear_m;
  logic clear_o;
  int   checks;
  int   failures;

  sum_accumulator_if                               bm  ();
  sum_accumulator_if #(.ACC_W(17))                 b17 ();
  sum_accumulator_if #(.CNT_W(2))                  b2  ();
  sum_accumulator_if                               b1  ();

  sum_accumulator u_main (.clk(clk), .rst_n(rst_n), .clear(clear_m), .bus(bm));
  sum_accumulator #(.ACC_W(17)) u_acc17 (.clk(clk), .rst_n(rst_n), .clear(clear_o), .bus(b17));
  sum_accumulator #(.CNT_W(2), .BLOCK_LEN(5)) u_cnt2 (.clk(clk), .rst_n(rst_n), .clear(clear_o), .bus(b2));
  sum_accumulator #(.BLOCK_LEN(1)) u_blk1 (.clk(clk), .rst_n(rst_n), .clear(clear_o), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({bm.in_ready, bm.out_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_hs got=%b exp=10", {bm.in_ready, bm.out_valid});
    end
    checks++;
    if ({bm.acc_s, bm.acc_t, bm.sat, bm.ovf_cnt} !== '0) begin
      failures++; $display("FAIL reset_regs acc_s=%h acc_t=%h sat=%b ovf=%h exp all zero",
                           bm.acc_s, bm.acc_t, bm.sat, bm.ovf_cnt);
    end
  endtask

  task automatic test_basic();
    bm.in_valid = 1'b1; bm.s_in = 17'h00010; bm.t_in = 9'h003; bm.ovf_in = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({bm.out_valid, bm.in_ready, bm.acc_s} !== {2'b01, 24'h30}) begin
      failures++; $display("FAIL basic_partial ov=%b ir=%b acc_s=%h exp ov=0 ir=1 acc_s=30",
                           bm.out_valid, bm.in_ready, bm.acc_s);
    end
    cyc();
    bm.in_valid = 1'b0;
    checks++;
    if ({bm.out_valid, bm.in_ready} !== 2'b10) begin
      failures++; $display("FAIL basic_hs got=%b exp=10", {bm.out_valid, bm.in_ready});
    end
    checks++;
    if (bm.acc_s !== 24'h40 || bm.acc_t !== 24'h0C) begin
      failures++; $display("FAIL basic_acc acc_s=%h acc_t=%h exp 40/0c", bm.acc_s, bm.acc_t);
    end
    checks++;
    if ({bm.sat, bm.ovf_cnt} !== 9'h0) begin
      failures++; $display("FAIL basic_flags sat=%b ovf=%h exp 0/00", bm.sat, bm.ovf_cnt);
    end
  endtask

  task automatic test_hold_backpressure();
    bm.in_valid = 1'b1; bm.s_in = 17'h00005; bm.t_in = 9'h001; bm.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t} !== {2'b01, 24'h40, 24'h0C}) begin
        failures++; $display("FAIL hold_stable cyc=%0d ir=%b ov=%b acc_s=%h acc_t=%h exp 0 1 40 0c",
                             i, bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t);
      end
    end
    bm.in_valid = 1'b0; bm.out_ready = 1'b1;
    cyc();
    bm.out_ready = 1'b0;
    checks++;
    if ({bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t} !== {2'b10, 48'h0}) begin
      failures++; $display("FAIL hold_release ir=%b ov=%b acc_s=%h acc_t=%h exp 1 0 0 0",
                           bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t);
    end
  endtask

  task automatic test_ovf_pattern();
    logic [3:0] pat;
    pat = 4'b1101;
    bm.s_in = 17'h00001; bm.t_in = 9'h001;
    for (int i = 0; i < 4; i++) begin
      bm.in_valid = 1'b1; bm.ovf_in = pat[i];
      cyc();
    end
    bm.in_valid = 1'b0; bm.ovf_in = 1'b0;
    checks++;
    if ({bm.out_valid, bm.ovf_cnt, bm.acc_s} !== {1'b1, 8'd3, 24'h4}) begin
      failures++; $display("FAIL ovf_pattern ov=%b ovf=%0d acc_s=%h exp 1 3 4",
                           bm.out_valid, bm.ovf_cnt, bm.acc_s);
    end
    bm.out_ready = 1'b1;
    cyc();
    bm.out_ready = 1'b0;
  endtask

  task automatic test_ovf_saturate();
    b2.in_valid = 1'b1; b2.s_in = '0; b2.t_in = '0; b2.ovf_in = 1'b1; b2.out_ready = 1'b0;
    repeat (4) cyc();
    checks++;
    if ({b2.out_valid, b2.ovf_cnt} !== 3'b011) begin
      failures++; $display("FAIL ovf_sat_partial ov=%b ovf=%b exp 0 11", b2.out_valid, b2.ovf_cnt);
    end
    cyc();
    b2.in_valid = 1'b0; b2.ovf_in = 1'b0;
    checks++;
    if ({b2.out_valid, b2.ovf_cnt} !== 3'b111) begin
      failures++; $display("FAIL ovf_sat_frame ov=%b ovf=%b exp 1 11", b2.out_valid, b2.ovf_cnt);
    end
    b2.out_ready = 1'b1;
    cyc();
    b2.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    b17.in_valid = 1'b1; b17.s_in = 17'h1FFFF; b17.t_in = 9'h001; b17.ovf_in = 1'b0;
    b17.out_ready = 1'b0;
    cyc();
    checks++;
    if ({b17.acc_s, b17.sat} !== {17'h1FFFF, 1'b0}) begin
      failures++; $display("FAIL sat_exact acc_s=%h sat=%b exp 1ffff 0", b17.acc_s, b17.sat);
    end
    repeat (3) cyc();
    b17.in_valid = 1'b0;
    checks++;
    if ({b17.out_valid, b17.acc_s, b17.sat, b17.acc_t} !== {1'b1, 17'h1FFFF, 1'b1, 17'h4}) begin
      failures++; $display("FAIL sat_frame ov=%b acc_s=%h sat=%b acc_t=%h exp 1 1ffff 1 4",
                           b17.out_valid, b17.acc_s, b17.sat, b17.acc_t);
    end
    b17.out_ready = 1'b1;
    cyc();
    b17.out_ready = 1'b0;
    b17.in_valid = 1'b1; b17.s_in = 17'h00002; b17.t_in = 9'h000;
    cyc();
    b17.in_valid = 1'b0;
    checks++;
    if ({b17.acc_s, b17.sat} !== {17'h2, 1'b0}) begin
      failures++; $display("FAIL sat_next_block acc_s=%h sat=%b exp 2 0", b17.acc_s, b17.sat);
    end
  endtask

  task automatic test_clear();
    bm.in_valid = 1'b1; bm.s_in = 17'h00010; bm.t_in = 9'h003; bm.ovf_in = 1'b1;
    repeat (2) cyc();
    clear_m = 1'b1; bm.s_in = 17'h00100;
    cyc();
    clear_m = 1'b0; bm.in_valid = 1'b0; bm.ovf_in = 1'b0;
    checks++;
    if ({bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t, bm.ovf_cnt} !== {2'b10, 56'h0}) begin
      failures++; $display("FAIL clear_zero ir=%b ov=%b acc_s=%h acc_t=%h ovf=%h exp 1 0 0 0 0",
                           bm.in_ready, bm.out_valid, bm.acc_s, bm.acc_t, bm.ovf_cnt);
    end
    bm.in_valid = 1'b1; bm.s_in = 17'h00010;
    repeat (3) cyc();
    checks++;
    if (bm.out_valid !== 1'b0) begin
      failures++; $display("FAIL clear_count ov=%b exp 0 after 3 accepts", bm.out_valid);
    end
    cyc();
    bm.in_valid = 1'b0;
    checks++;
    if ({bm.out_valid, bm.acc_s, bm.acc_t} !== {1'b1, 24'h40, 24'h0C}) begin
      failures++; $display("FAIL clear_frame ov=%b acc_s=%h acc_t=%h exp 1 40 0c",
                           bm.out_valid, bm.acc_s, bm.acc_t);
    end
    clear_m = 1'b1; bm.out_ready = 1'b1;
    cyc();
    clear_m = 1'b0; bm.out_ready = 1'b0;
    checks++;
    if ({bm.in_ready, bm.out_valid, bm.acc_s} !== {2'b10, 24'h0}) begin
      failures++; $display("FAIL clear_hold ir=%b ov=%b acc_s=%h exp 1 0 0",
                           bm.in_ready, bm.out_valid, bm.acc_s);
    end
  endtask

  task automatic test_async_reset();
    bm.in_valid = 1'b1; bm.s_in = 17'h00010; bm.t_in = 9'h003; bm.ovf_in = 1'b1;
    repeat (2) cyc();
    bm.in_valid = 1'b0; bm.ovf_in = 1'b0;
    checks++;
    if ({bm.acc_s, bm.ovf_cnt} !== {24'h20, 8'd2}) begin
      failures++; $display("FAIL areset_pre acc_s=%h ovf=%0d exp 20 2", bm.acc_s, bm.ovf_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bm.acc_s, bm.acc_t, bm.ovf_cnt} !== 56'h0) begin
      failures++; $display("FAIL areset_async acc_s=%h acc_t=%h ovf=%h exp 0 0 0",
                           bm.acc_s, bm.acc_t, bm.ovf_cnt);
    end
    #2 rst_n = 1'b1;
    cyc();
    checks++;
    if ({bm.in_ready, bm.out_valid} !== 2'b10) begin
      failures++; $display("FAIL areset_hs got=%b exp 10", {bm.in_ready, bm.out_valid});
    end
  endtask

  task automatic test_block_len_one();
    b1.t_in = 9'h000; b1.ovf_in = 1'b0; b1.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b1.in_valid = 1'b1; b1.s_in = 17'(i + 1);
      cyc();
      b1.in_valid = 1'b0;
      checks++;
      if ({b1.out_valid, b1.in_ready, b1.acc_s} !== {2'b10, 24'(i + 1)}) begin
        failures++; $display("FAIL blk1_frame n=%0d ov=%b ir=%b acc_s=%h exp 1 0 %h",
                             i, b1.out_valid, b1.in_ready, b1.acc_s, 24'(i + 1));
      end
      b1.out_ready = 1'b1;
      cyc();
      b1.out_ready = 1'b0;
    end
    checks++;
    if ({b1.out_valid, b1.in_ready} !== 2'b01) begin
      failures++; $display("FAIL blk1_idle ov=%b ir=%b exp 0 1", b1.out_valid, b1.in_ready);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; clear_m = 1'b0; clear_o = 1'b0;
    bm.in_valid = 1'b0;  bm.s_in = '0;  bm.t_in = '0;  bm.ovf_in = 1'b0;  bm.out_ready = 1'b0;
    b17.in_valid = 1'b0; b17.s_in = '0; b17.t_in = '0; b17.ovf_in = 1'b0; b17.out_ready = 1'b0;
    b2.in_valid = 1'b0;  b2.s_in = '0;  b2.t_in = '0;  b2.ovf_in = 1'b0;  b2.out_ready = 1'b0;
    b1.in_valid = 1'b0;  b1.s_in = '0;  b1.t_in = '0;  b1.ovf_in = 1'b0;  b1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold_backpressure();
    test_ovf_pattern();
    test_ovf_saturate();
    test_saturation();
    test_clear();
    test_async_reset();
    test_block_len_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
